// File: rtl/apb_node_wd.sv
// APB address-decoding node with a slave-response watchdog.
// Routes one master to NB_SLAVES windows, aborts slaves that never become ready.
module apb_node_wd #(
  parameter int NB_SLAVES      = 10,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [APB_ADDR_WIDTH-1:0]            m_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]            m_pwdata_i,
  input  logic                                 m_pwrite_i,
  input  logic                                 m_psel_i,
  input  logic                                 m_penable_i,
  output logic [APB_DATA_WIDTH-1:0]            m_prdata_o,
  output logic                                 m_pready_o,
  output logic                                 m_pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]            s_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]            s_pwdata_o,
  output logic                                 s_pwrite_o,
  output logic                                 s_penable_o,
  output logic [NB_SLAVES-1:0]                 s_psel_o,
  input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0]  s_prdata_i,
  input  logic [NB_SLAVES-1:0]                 s_pready_i,
  input  logic [NB_SLAVES-1:0]                 s_pslverr_i,
  input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0]  start_addr_i,
  input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0]  end_addr_i,
  output logic                                 err_valid_o,
  output logic                                 err_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0]            err_addr_o,
  output logic [15:0]                          err_cnt_o
);

  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;
  localparam int IW = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic            hit_any;
  logic [IW-1:0]   win;
  logic            access;
  logic            blocked;
  logic            sel_ready;
  logic            sel_err;
  logic [DW-1:0]   sel_rdata;
  logic            timeout;
  logic            dec_err;
  logic            err_event;

  assign s_paddr_o   = m_paddr_i;
  assign s_pwdata_o  = m_pwdata_i;
  assign s_pwrite_o  = m_pwrite_i;
  assign s_penable_o = m_penable_i;

  // Window decode; scanning downward leaves the lowest hit as winner
  always_comb begin
    hit_any = 1'b0;
    win     = '0;
    for (int k = NB_SLAVES - 1; k >= 0; k--) begin
      if (m_paddr_i >= start_addr_i[k*AW +: AW] &&
          m_paddr_i <= end_addr_i[k*AW +: AW]) begin
        hit_any = 1'b1;
        win     = IW'(k);
      end
    end
  end

  assign access    = m_psel_i & m_penable_i;
  // An aborted transfer stays blocked until the master starts a new setup
  assign blocked   = (state == ABORT) & access;
  assign sel_ready = s_pready_i[win];
  assign sel_err   = s_pslverr_i[win];
  assign sel_rdata = s_prdata_i[int'(win)*DW +: DW];

  assign timeout = (TIMEOUT_CYCLES != 0) && (state == WAIT) &&
                   access && hit_any && !sel_ready &&
                   (wait_cnt == CW'(TIMEOUT_CYCLES));
  assign dec_err   = access & ~hit_any & ~blocked;
  assign err_event = dec_err | timeout;

  // One-hot select towards the winning slave
  always_comb begin
    s_psel_o = '0;
    if (m_psel_i && hit_any && !blocked && !rst)
      s_psel_o[win] = 1'b1;
  end

  // Master response: forced error, slave mux, or idle zeros
  always_comb begin
    m_prdata_o  = '0;
    m_pready_o  = 1'b0;
    m_pslverr_o = 1'b0;
    if (m_psel_i && !blocked) begin
      if (err_event) begin
        m_pready_o  = 1'b1;
        m_pslverr_o = 1'b1;
      end else if (hit_any) begin
        m_prdata_o  = sel_rdata;
        m_pready_o  = sel_ready;
        m_pslverr_o = sel_err;
      end
    end
  end

  // Watchdog FSM and registered error reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      err_valid_o   <= 1'b0;
      err_timeout_o <= 1'b0;
      err_addr_o    <= '0;
      err_cnt_o     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access && hit_any && !sel_ready) begin
            state    <= WAIT;
            wait_cnt <= CW'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (!access || !hit_any || sel_ready) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (timeout) begin
            state    <= ABORT;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ABORT: begin
          wait_cnt <= '0;
          if (!access)
            state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
      err_valid_o <= err_event;
      if (err_event) begin
        err_timeout_o <= timeout;
        err_addr_o    <= m_paddr_i;
        if (err_cnt_o != 16'hFFFF)
          err_cnt_o <= err_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_apb_node_wd.sv
// Directed bench for apb_node_wd: decode table plus
// watchdog, reset and counter-saturation sequences.
module tb_apb_node_wd;

  localparam int NS = 10;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     m_paddr;
  logic [DW-1:0]     m_pwdata;
  logic              m_pwrite;
  logic              m_psel;
  logic              m_penable;
  logic [DW-1:0]     m_prdata;
  logic              m_pready;
  logic              m_pslverr;
  logic [AW-1:0]     s_paddr;
  logic [DW-1:0]     s_pwdata;
  logic              s_pwrite;
  logic              s_penable;
  logic [NS-1:0]     s_psel;
  logic [NS*DW-1:0]  s_prdata;
  logic [NS-1:0]     s_pready;
  logic [NS-1:0]     s_pslverr;
  logic [NS*AW-1:0]  start_addr;
  logic [NS*AW-1:0]  end_addr;
  logic              err_valid;
  logic              err_timeout;
  logic [AW-1:0]     err_addr;
  logic [15:0]       err_cnt;

  int checks = 0;
  int errors = 0;

  apb_node_wd #(
    .NB_SLAVES(NS), .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_paddr_i(m_paddr), .m_pwdata_i(m_pwdata),
    .m_pwrite_i(m_pwrite), .m_psel_i(m_psel),
    .m_penable_i(m_penable),
    .m_prdata_o(m_prdata), .m_pready_o(m_pready),
    .m_pslverr_o(m_pslverr),
    .s_paddr_o(s_paddr), .s_pwdata_o(s_pwdata),
    .s_pwrite_o(s_pwrite), .s_penable_o(s_penable),
    .s_psel_o(s_psel),
    .s_prdata_i(s_prdata), .s_pready_i(s_pready),
    .s_pslverr_i(s_pslverr),
    .start_addr_i(start_addr), .end_addr_i(end_addr),
    .err_valid_o(err_valid), .err_timeout_o(err_timeout),
    .err_addr_o(err_addr), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          psel;
    logic          pen;
    logic [NS-1:0] slverr;
    logic [NS-1:0] x_psel;
    logic [DW-1:0] x_rdata;
    logic          x_rdy;
    logic          x_err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [AW-1:0] a,
                       input logic ps, input logic pe);
    @(negedge clk);
    m_paddr   = a;
    m_psel    = ps;
    m_penable = pe;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m_psel = 1'b0;
    m_penable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m_paddr = '0;
    m_pwdata = 32'hCAFE_F00D;
    m_pwrite = 1'b0;
    m_psel = 1'b0;
    m_penable = 1'b0;
    s_pready = '1;
    s_pslverr = '0;
    for (int k = 0; k < NS; k++) begin
      s_prdata[k*DW +: DW]   = 32'hD000_0000 + k;
      start_addr[k*AW +: AW] = 32'h1A10_0000 + k * 32'h1000;
      end_addr[k*AW +: AW]   = 32'h1A10_0FFF + k * 32'h1000;
    end
    start_addr[5*AW +: AW] = 32'h1A10_2000;
    end_addr[5*AW +: AW]   = 32'h1A10_5FFF;

    tbl[0]  = '{32'h1A10_3FFC, 1, 1, 0, 10'h008, 32'hD000_0003, 1, 0};
    tbl[1]  = '{32'h1A10_3FFC, 1, 0, 0, 10'h008, 32'hD000_0003, 1, 0};
    tbl[2]  = '{32'h1A10_3FFC, 0, 0, 0, 10'h000, 32'h0, 0, 0};
    tbl[3]  = '{32'h1A20_0000, 1, 1, 0, 10'h000, 32'h0, 1, 1};
    tbl[4]  = '{32'h1A20_0000, 1, 0, 0, 10'h000, 32'h0, 0, 0};
    tbl[5]  = '{32'h1A10_2800, 1, 1, 0, 10'h004, 32'hD000_0002, 1, 0};
    tbl[6]  = '{32'h1A10_5800, 1, 1, 0, 10'h020, 32'hD000_0005, 1, 0};
    tbl[7]  = '{32'h1A10_0000, 1, 1, 0, 10'h001, 32'hD000_0000, 1, 0};
    tbl[8]  = '{32'h1A10_9FFF, 1, 1, 0, 10'h200, 32'hD000_0009, 1, 0};
    tbl[9]  = '{32'h1A10_A000, 1, 1, 0, 10'h000, 32'h0, 1, 1};
    tbl[10] = '{32'h1A10_0FFF, 1, 1, 0, 10'h001, 32'hD000_0000, 1, 0};
    tbl[11] = '{32'h1A10_4000, 1, 1, 10'h010, 10'h010, 32'hD000_0004, 1, 1};

    // reset state, with a mapped access pending
    drive(32'h1A10_3FFC, 1, 1);
    chk("rst_psel", 64'(s_psel), 0);
    chk("rst_valid", 64'(err_valid), 0);
    chk("rst_cnt", 64'(err_cnt), 0);
    chk("rst_addr", 64'(err_addr), 0);
    chk("rst_tmo", 64'(err_timeout), 0);
    rst = 1'b0;

    // decode table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      m_paddr   = tbl[i].addr;
      m_psel    = tbl[i].psel;
      m_penable = tbl[i].pen;
      s_pslverr = tbl[i].slverr;
      #1;
      chk($sformatf("t%0d_psel", i), 64'(s_psel), 64'(tbl[i].x_psel));
      chk($sformatf("t%0d_rdata", i), 64'(m_prdata), 64'(tbl[i].x_rdata));
      chk($sformatf("t%0d_rdy", i), 64'(m_pready), 64'(tbl[i].x_rdy));
      chk($sformatf("t%0d_err", i), 64'(m_pslverr), 64'(tbl[i].x_err));
      chk($sformatf("t%0d_paddr", i), 64'(s_paddr), 64'(tbl[i].addr));
    end
    s_pslverr = '0;
    drive(32'h0, 0, 0);
    chk("tbl_cnt", 64'(err_cnt), 2);

    // unmapped read -> error pulse next cycle
    do_reset();
    drive(32'h1A20_0000, 1, 1);
    chk("dec_rdy", 64'(m_pready), 1);
    chk("dec_err", 64'(m_pslverr), 1);
    drive(32'h0, 0, 0);
    chk("dec_valid", 64'(err_valid), 1);
    chk("dec_tmo", 64'(err_timeout), 0);
    chk("dec_cnt", 64'(err_cnt), 1);
    chk("dec_addr", 64'(err_addr), 64'h1A20_0000);
    drive(32'h0, 0, 0);
    chk("dec_pulse", 64'(err_valid), 0);

    // slave 1 never ready -> timeout on 5th access cycle
    s_pready = '1;
    s_pready[1] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      drive(32'h1A10_1004, 1, 1);
      chk($sformatf("to_wait%0d", c), 64'(m_pready), 0);
    end
    drive(32'h1A10_1004, 1, 1);
    chk("to_rdy", 64'(m_pready), 1);
    chk("to_err", 64'(m_pslverr), 1);
    chk("to_rdata", 64'(m_prdata), 0);
    drive(32'h1A10_1004, 1, 1);
    chk("ab_psel", 64'(s_psel), 0);
    chk("ab_valid", 64'(err_valid), 1);
    chk("ab_tmo", 64'(err_timeout), 1);
    chk("ab_addr", 64'(err_addr), 64'h1A10_1004);
    chk("ab_cnt", 64'(err_cnt), 2);
    drive(32'h1A10_1004, 1, 0);
    chk("ab_exit_psel", 64'(s_psel), 64'h002);
    drive(32'h0, 0, 0);
    chk("ab_hold_tmo", 64'(err_timeout), 1);

    // slave ready exactly on the timeout cycle
    for (int c = 1; c <= 4; c++)
      drive(32'h1A10_1008, 1, 1);
    @(negedge clk);
    s_pready[1] = 1'b1;
    s_pslverr[1] = 1'b1;
    #1;
    chk("late_rdy", 64'(m_pready), 1);
    chk("late_err", 64'(m_pslverr), 1);
    chk("late_rdata", 64'(m_prdata), 64'hD000_0001);
    drive(32'h0, 0, 0);
    chk("late_valid", 64'(err_valid), 0);
    chk("late_cnt", 64'(err_cnt), 2);
    s_pslverr = '0;

    // reset during WAIT, then fresh tracking
    s_pready[1] = 1'b0;
    drive(32'h1A10_1000, 1, 1);
    drive(32'h1A10_1000, 1, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("wr_psel", 64'(s_psel), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("wr_cnt", 64'(err_cnt), 0);
    chk("wr_tmo", 64'(err_timeout), 0);
    chk("wr_addr", 64'(err_addr), 0);
    chk("wr_valid", 64'(err_valid), 0);
    chk("wr_fresh_psel", 64'(s_psel), 64'h002);
    chk("wr_fresh_rdy1", 64'(m_pready), 0);
    for (int c = 2; c <= 4; c++) begin
      drive(32'h1A10_1000, 1, 1);
      chk($sformatf("wr_fresh_rdy%0d", c), 64'(m_pready), 0);
    end
    drive(32'h1A10_1000, 1, 1);
    chk("wr_fresh_to", 64'(m_pready), 1);
    drive(32'h0, 0, 0);
    s_pready = '1;

    // 65536 decode errors -> counter saturates
    do_reset();
    @(negedge clk);
    m_paddr = 32'h1A20_0000;
    m_psel = 1'b1;
    m_penable = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", 64'(err_cnt), 64'hFFFE);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_ffff", 64'(err_cnt), 64'hFFFF);
    @(posedge clk);
    #1;
    chk("sat_hold", 64'(err_cnt), 64'hFFFF);
    m_psel = 1'b0;
    m_penable = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_node_wd.md
APB_NODE_WD -- requirements
Module: apb_node_wd

Interface
- REQ-001 Parameter NB_SLAVES, default 10: number of APB slave ports.
- REQ-002 Parameter APB_ADDR_WIDTH, default 32: address width.
- REQ-003 Parameter APB_DATA_WIDTH, default 32: data width.
- REQ-004 Parameter TIMEOUT_CYCLES, default 255: not-ready access cycles tolerated; 0 disables the watchdog.
- REQ-005 One clock; reset is synchronous and active-high.
- REQ-006 clk  in  1  clock; all state updates on the rising edge.
- REQ-007 rst  in  1  synchronous active-high reset.
- REQ-008 m_paddr_i, m_pwdata_i, m_pwrite_i, m_psel_i, m_penable_i  in  AW/DW/1/1/1  upstream APB request.
- REQ-009 m_prdata_o, m_pready_o, m_pslverr_o  out  DW/1/1  upstream APB response.
- REQ-010 s_paddr_o, s_pwdata_o, s_pwrite_o, s_penable_o  out  AW/DW/1/1  request broadcast to all slaves.
- REQ-011 s_psel_o  out  NB_SLAVES  one-hot slave select.
- REQ-012 s_prdata_i, s_pready_i, s_pslverr_i  in  NB_SLAVES*DW / NB_SLAVES / NB_SLAVES  slave responses, slave k at slice k.
- REQ-013 start_addr_i, end_addr_i  in  NB_SLAVES*AW each  inclusive address window of slave k.
- REQ-014 err_valid_o  out  1  one-cycle pulse per error response; err_timeout_o  out  1  1=timeout, 0=decode error.
- REQ-015 err_addr_o  out  AW  paddr of last error; err_cnt_o  out  16  saturating error count.

Function
- REQ-016 Decode: hit[k] = start_addr_i[k] <= m_paddr_i <= end_addr_i[k]; lowest index wins on overlap; no hit = unmapped.
- REQ-017 s_paddr_o/s_pwdata_o/s_pwrite_o/s_penable_o follow master inputs combinationally; s_psel_o[k] = m_psel_i & winner==k & state!=ABORT & ~rst.
- REQ-018 Master response mapped: m_prdata_o/m_pready_o/m_pslverr_o = selected slave's, zero-latency mux.
- REQ-019 m_psel_i=0: m_prdata_o=0, m_pready_o=0, m_pslverr_o=0.
- REQ-020 Unmapped, access phase (m_psel_i&m_penable_i): m_pready_o=1, m_pslverr_o=1, m_prdata_o=0 on the first access cycle; no s_psel_o asserted.
- REQ-021 States IDLE, WAIT, ABORT; wait_cnt width ceil(log2(TIMEOUT_CYCLES+1)).
- REQ-022 IDLE: access cycle with mapped slave and pready=0 -> WAIT, wait_cnt=1; pready=1 -> stay IDLE.
- REQ-023 WAIT: slave pready=1 -> IDLE, wait_cnt=0; else wait_cnt+1; m_psel_i=0 -> IDLE, wait_cnt=0.
- REQ-024 Timeout: in WAIT with wait_cnt==TIMEOUT_CYCLES and slave pready=0, node forces m_pready_o=1, m_pslverr_o=1, m_prdata_o=0 that cycle, next state ABORT.
- REQ-025 Slave pready=1 on the timeout cycle: slave response wins, no error.
- REQ-026 ABORT: all s_psel_o=0; exit to IDLE when m_psel_i=0 or m_penable_i=0 (new setup), same cycle decode resumes.
- REQ-027 TIMEOUT_CYCLES=0: never leaves IDLE/WAIT for ABORT; no timeouts.
- REQ-028 Each error response (decode or timeout): err_valid_o=1 next cycle for one cycle, err_timeout_o/err_addr_o registered, err_cnt_o+1 saturating at 16'hFFFF.
- REQ-029 err_timeout_o/err_addr_o hold until the next error.

Reset
- REQ-030 While rst=1: state IDLE, wait_cnt=0, s_psel_o=0, err_valid_o=0, err_timeout_o=0, err_addr_o=0, err_cnt_o=0.
- REQ-031 Reset asserted mid-transfer aborts tracking; after release, first cycle decodes fresh from master inputs.

Verification
- REQ-032 Slave 3 window 0x1A10_3000..0x1A10_3FFF, read 0x1A10_3FFC, pready=1 -> s_psel_o=0x008, m_prdata_o=slave3 data, no error.
- REQ-033 Read 0x1A20_0000 (unmapped) -> m_pready_o=1, m_pslverr_o=1, prdata=0 on first access cycle; next cycle err_valid_o=1, err_timeout_o=0, err_cnt_o=1.
- REQ-034 TIMEOUT_CYCLES=4, slave 1 never ready -> error response on 5th access cycle, s_psel_o=0 next cycle, err_timeout_o=1, err_addr_o=paddr.
- REQ-035 TIMEOUT_CYCLES=4, slave pready=1 exactly on 5th access cycle -> normal response, pslverr from slave, err_cnt_o unchanged.
- REQ-036 Overlapping windows slaves 2 and 5, address in both -> s_psel_o=0x004 only.
- REQ-037 rst=1 during WAIT -> next cycle all outputs at reset values; 65536 forced errors -> err_cnt_o stays 16'hFFFF.
